npu_seq: RTL
============

NPU_SEQ -- requirements
Module: npu_seq

Interface
REQ-001 The block SHALL take parameter NUM_PE, default 4, meaning FC weight lanes per stream beat, 1..4, 8 bits each.
REQ-002 The block SHALL take parameter N_LAYER, default 2, meaning conv layers per inference, 1..4.
REQ-003 The block SHALL take parameter N_CHAN, default 10, meaning conv passes (channels) per layer, 1..16.
REQ-004 The block SHALL take parameter PIX_CNT, default 132, meaning conv_valid pulses that end one conv pass.
REQ-005 The block SHALL take parameter FIFO_DEPTH, default 8, meaning weight FIFO entries, a power of two of at least 2.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have ports ena, wea, addra and dina, inputs of 1, 1, 16 and 32 bits: the host port; sel=addra[14:12], idx=addra[11:0].
REQ-009 The block SHALL have port douta, output, 32 bits: registered host read data.
REQ-010 The block SHALL have ports conv_trigger, conv_clear, conv_layer and conv_chan, outputs of 1, 1, 2 and 4 bits: conv engine control.
REQ-011 The block SHALL have port conv_valid, input, 1 bit: one pulse per conv output pixel.
REQ-012 The block SHALL have ports fc_start, fc_w_valid and fc_w, outputs of 1, 1 and NUM_PE*8 bits: FC control and weight stream.
REQ-013 The block SHALL have ports fc_w_ready, fc_done and fc_logit, inputs of 1, 1 and 24 bits (fc_logit signed): FC handshake and result.
REQ-014 The block SHALL have port irq, output, 1 bit: sticky done interrupt.

Function
REQ-015 A host write SHALL be ena&wea; a host read SHALL be ena&~wea; writes with sel outside {011,101} SHALL be ignored.
REQ-016 sel=011 writes SHALL push dina[NUM_PE*8-1:0] into the weight FIFO.
- FIFO full: the push is dropped and sticky ovf is set.
- Push and pop in the same cycle when full: both succeed and count is unchanged.
REQ-017 sel=101, idx=0 writes SHALL decode as: bit0 start, bit1 auto (latched only with start), bit2 abort, bit3 step.
REQ-018 sel=101, idx=1 writes SHALL clear irq, done and ovf.
REQ-019 FSM states SHALL be IDLE, CLR, CONV, WAIT, STEP, FC and DONE.
REQ-020 IDLE SHALL move to CLR on start and clear the layer, chan and pixel counters; start in any other state SHALL be ignored.
REQ-021 CLR SHALL assert conv_clear for exactly 1 cycle and then go to CONV.
REQ-022 CONV SHALL assert conv_trigger for exactly 1 cycle, with conv_layer/conv_chan equal to the counters, and then go to WAIT.
REQ-023 WAIT SHALL count conv_valid pulses; after PIX_CNT pulses it SHALL advance chan, wrap chan to 0 and increment layer.
- After the last layer/chan pass: go to FC with fc_start asserted for 1 cycle.
- Otherwise, auto=1: go to CLR.
- Otherwise, auto=0: go to STEP.
REQ-024 STEP SHALL wait for step and then go to CLR.
REQ-025 In FC, fc_w_valid SHALL equal ~fifo_empty and fc_w SHALL equal the FIFO head; a pop SHALL occur on fc_w_valid&fc_w_ready.
REQ-026 FC SHALL go to DONE on fc_done and capture fc_logit into result.
REQ-027 DONE SHALL set done and irq, then return to IDLE after 1 cycle.
REQ-028 Abort SHALL force IDLE from any state on the next edge, flush the FIFO and leave done/irq unchanged; abort SHALL take priority over start and step in the same cycle.
REQ-029 conv_valid pulses outside WAIT SHALL be ignored.
REQ-030 The pixel counter SHALL be $clog2(PIX_CNT+1) bits wide.
REQ-031 douta SHALL update on the edge after a read and hold its value otherwise.
- idx0 (status): {ovf[5], fifo_count[?:8], state[4:2], busy[1], done[0]}, with all other bits 0.
- idx1: result sign-extended to 32 bits.
- idx2: {chan[7:4], layer[1:0]}, with all other bits 0.
- Any other idx: 0.
REQ-032 busy SHALL be 1 whenever state is not IDLE.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL enter IDLE.
- Zeroed: the FIFO (count 0) and all counters.
- Zeroed: result, done, ovf, auto, irq, douta and every control output.
- Taken: this happens regardless of ena/wea.
REQ-034 Reset asserted mid-pass SHALL discard the pass; no conv_trigger or fc_start SHALL be issued on the cycle after reset deasserts.

Verification
REQ-035 Auto run (N_LAYER=2, N_CHAN=2, PIX_CNT=4), 3 weight words pushed, fc_w_ready held high, fc_done returned with fc_logit=-5 -> the bench SHALL observe:
- 4 conv_clear/conv_trigger pairs with (layer,chan) = (0,0),(0,1),(1,0),(1,1);
- 3 beats in push order;
- result read = 0xFFFFFFFB, irq=1.
REQ-036 Step mode, same stimulus -> the bench SHALL observe the FSM parked in STEP after each pass, and no conv_trigger until a step write.
REQ-037 Nine weight pushes with FIFO_DEPTH=8 -> the bench SHALL observe status fifo_count=8, ovf=1, and the ninth word never streamed.
REQ-038 Abort written during WAIT at pixel 2 -> the bench SHALL observe state IDLE and fifo_count 0 next cycle, and conv_valid afterwards ignored.
REQ-039 rst asserted during FC, then a read of idx0 -> the bench SHALL read 0, with irq=0 and fc_w_valid=0.
REQ-040 start and abort written together in IDLE -> the bench SHALL observe the FSM remaining in IDLE.

Source files
------------

// File: rtl/npu_seq.sv
// npu_seq: NPU inference sequencer.
// Sequences conv passes (layer x channel), streams FC weights from a host-filled
// FIFO, captures the FC logit and raises a sticky done interrupt.
module npu_seq #(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned N_LAYER    = 2,
  parameter int unsigned N_CHAN     = 10,
  parameter int unsigned PIX_CNT    = 132,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    wea,
  input  logic [15:0]             addra,
  input  logic [31:0]             dina,
  output logic [31:0]             douta,
  output logic                    conv_trigger,
  output logic                    conv_clear,
  output logic [1:0]              conv_layer,
  output logic [3:0]              conv_chan,
  input  logic                    conv_valid,
  output logic                    fc_start,
  output logic                    fc_w_valid,
  output logic [NUM_PE*8-1:0]     fc_w,
  input  logic                    fc_w_ready,
  input  logic                    fc_done,
  input  logic signed [23:0]      fc_logit,
  output logic                    irq
);

  localparam int unsigned W     = NUM_PE * 8;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PIX_W = $clog2(PIX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    CONV = 3'd2,
    WAIT = 3'd3,
    STEP = 3'd4,
    FC   = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic              clr_nxt, trig_nxt, fcs_nxt;
  logic [PIX_W-1:0]  pix;
  logic              auto_q;
  logic              done, ovf;
  logic [23:0]       result;
  logic [W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       rdata;

  // Host port decode
  logic [2:0]  sel;
  logic [11:0] idx;
  logic        host_wr, host_rd, ctrl_wr, start, abort, step, irq_clr, push_req;
  logic        unused_bits;

  assign sel         = addra[14:12];
  assign idx         = addra[11:0];
  assign host_wr     = ena & wea;
  assign host_rd     = ena & ~wea;
  assign ctrl_wr     = host_wr && (sel == 3'b101) && (idx == 12'd0);
  assign start       = ctrl_wr & dina[0];
  assign abort       = ctrl_wr & dina[2];
  assign step        = ctrl_wr & dina[3];
  assign irq_clr     = host_wr && (sel == 3'b101) && (idx == 12'd1);
  assign push_req    = host_wr && (sel == 3'b011);
  assign unused_bits = addra[15];

  // FIFO status and FC weight stream
  logic fifo_empty, fifo_full, pop, push_ok;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fc_w_valid = (state == FC) && !fifo_empty;
  assign fc_w       = fc_w_valid ? mem[rd_ptr] : '0;
  assign pop        = fc_w_valid & fc_w_ready;
  assign push_ok    = push_req && (!fifo_full || pop);

  // Pass bookkeeping
  logic last_pass, pass_done;
  assign last_pass = (conv_layer == 2'(N_LAYER - 1)) && (conv_chan == 4'(N_CHAN - 1));
  assign pass_done = (state == WAIT) && conv_valid && (pix == PIX_W'(PIX_CNT - 1));

  // Next-state and control pulse decode; abort overrides everything
  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    trig_nxt  = 1'b0;
    fcs_nxt   = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nxt = CLR;
        CLR:  state_nxt = CONV;
        CONV: state_nxt = WAIT;
        WAIT: if (pass_done) begin
                if (last_pass)   state_nxt = FC;
                else if (auto_q) state_nxt = CLR;
                else             state_nxt = STEP;
              end
        STEP: if (step) state_nxt = CLR;
        FC:   if (fc_done) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    clr_nxt  = (state_nxt == CLR);
    trig_nxt = (state_nxt == CONV);
    fcs_nxt  = (state_nxt == FC) && (state != FC);
  end

  // State register and registered control pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      conv_clear   <= 1'b0;
      conv_trigger <= 1'b0;
      fc_start     <= 1'b0;
    end else begin
      state        <= state_nxt;
      conv_clear   <= clr_nxt;
      conv_trigger <= trig_nxt;
      fc_start     <= fcs_nxt;
    end
  end

  // Layer / channel / pixel counters; auto mode latched on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_layer <= '0;
      conv_chan  <= '0;
      pix        <= '0;
      auto_q     <= 1'b0;
    end else if (!abort) begin
      if ((state == IDLE) && start) begin
        conv_layer <= '0;
        conv_chan  <= '0;
        pix        <= '0;
        auto_q     <= dina[1];
      end else if ((state == WAIT) && conv_valid) begin
        if (pass_done) begin
          pix <= '0;
          if (conv_chan == 4'(N_CHAN - 1)) begin
            conv_chan  <= '0;
            conv_layer <= (conv_layer == 2'(N_LAYER - 1)) ? 2'd0 : conv_layer + 2'd1;
          end else begin
            conv_chan <= conv_chan + 4'd1;
          end
        end else begin
          pix <= pix + PIX_W'(1);
        end
      end
    end
  end

  // Weight FIFO pointers and occupancy; abort flushes
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // Weight FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= dina[W-1:0];
  end

  // Result capture, sticky done/irq/ovf
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      done   <= 1'b0;
      irq    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if ((state == FC) && fc_done && !abort) result <= fc_logit;
      if ((state == DONE) && !abort) begin
        done <= 1'b1;
        irq  <= 1'b1;
      end else if (irq_clr) begin
        done <= 1'b0;
        irq  <= 1'b0;
      end
      if (push_req && !push_ok) ovf <= 1'b1;
      else if (irq_clr)         ovf <= 1'b0;
    end
  end

  // Host read mux
  always_comb begin
    rdata = '0;
    case (idx)
      12'd0: begin
        rdata[0]           = done;
        rdata[1]           = (state != IDLE);
        rdata[4:2]         = state;
        rdata[5]           = ovf;
        rdata[8 +: CNT_W]  = count;
      end
      12'd1: rdata = {{8{result[23]}}, result};
      12'd2: begin
        rdata[7:4] = conv_chan;
        rdata[1:0] = conv_layer;
      end
      default: rdata = '0;
    endcase
  end

  // Registered host read data, held between reads
  always_ff @(posedge clk) begin
    if (rst)          douta <= '0;
    else if (host_rd) douta <= rdata;
  end

endmodule
